seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 4-bit calculator ALU.
- ADD/SUB complete in one compute cycle; MUL runs as an iterative shift-add and DIV as an iterative restoring divider, each taking WIDTH cycles.
- Sits between the operand/op-select front end and the result display path.
- Uses a start/busy/done handshake, so the controller knows when the result is valid.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..16).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A, latched on accept.
- B  input  WIDTH  operand B, latched on accept.
- op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; latched on accept.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse when the result becomes valid.
- result  output  2*WIDTH  sum, difference magnitude, product, or quotient (zero-extended).
- remainder  output  WIDTH  DIV remainder; 0 for other ops.
- negative  output  1  SUB result is negative.
- div_by_zero  output  1  DIV with B==0.

Behaviour:
- Reset (reset_n low, async): state=IDLE; busy, done, result, remainder, negative and div_by_zero all 0; internal registers and counter cleared.
- Reset mid-CALC aborts the operation; no done pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE: on a clock edge k with start=1, latch A, B and op; clear negative, div_by_zero and remainder; go to CALC; busy=1 from edge k.
- CALC ADD/SUB:
  - Single cycle; at edge k+1 write result, go to DONE.
  - ADD: result = A+B (WIDTH+1 bits, zero-extended).
  - SUB, A>=B: result = A-B, negative=0.
  - SUB, A<B: result = B-A (magnitude), negative=1.
- CALC MUL:
  - Shift-add over WIDTH iterations, LSB of B first.
  - Product valid at edge k+WIDTH; go to DONE.
- CALC DIV with B!=0:
  - Restoring division, MSB of A first, WIDTH iterations.
  - Quotient to result[WIDTH-1:0], upper bits 0; remainder to remainder.
  - Valid at edge k+WIDTH.
- CALC DIV with B==0:
  - At edge k+1: result = all ones, remainder = A, div_by_zero=1; go to DONE.
  - No iteration is performed.
- DONE: busy=0, done=1 for exactly one cycle; unconditional return to IDLE at the next edge.
- Result hold: result and flags hold their last values until the next accepted start. A start coincident with the DONE cycle is ignored; start is accepted only in IDLE.
- start while busy: ignored; latched operands are unaffected by changes on A, B or op during CALC.
- Latency, start edge to done high:
  - ADD/SUB: 1 cycle.
  - MUL: WIDTH cycles.
  - DIV with B!=0: WIDTH cycles.
  - DIV with B==0: 1 cycle.
- Throughput: one operation per latency+2 cycles.
- Width rules: all arithmetic is unsigned and full-width; no overflow is possible in a 2*WIDTH-bit result.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_EN.
- Defined: A and B are two's complement.
  - ADD/SUB: produce a sign-extended 2*WIDTH-bit two's-complement result; negative = result MSB.
  - MUL/DIV: operate on magnitudes, then restore sign. The quotient is negated if the operand signs differ; the remainder takes the sign of A, i.e. truncating division.
  - negative = sign of result.
  - Latency is unchanged: sign fix-up is combinational on the final iteration.
- Undefined: behaviour exactly as above (unsigned). negative is asserted only for SUB with A<B.

Test Plan:
- WIDTH=4: reset_n low mid-MUL (A=7, B=5, 2 cycles after start), release -> all outputs 0, state IDLE, no done pulse; subsequent ADD 5+3 -> result=8, done 1 cycle after start, negative=0.
- WIDTH=4: SUB A=3, B=5 -> result=2, negative=1, done after 1 cycle.
- WIDTH=8: MUL A=255, B=255 -> result=65025, done exactly 8 cycles after accept.
- WIDTH=8: DIV A=200, B=7 -> result=28, remainder=4.
- WIDTH=8: DIV A=9, B=0 -> div_by_zero=1, result=16'hFFFF, remainder=9, done after 1 cycle.
- Handshake:
  - WIDTH=8 MUL 12*10 with start held high and A/B toggled during CALC -> result=120, exactly one done pulse.
  - start asserted in the DONE cycle -> ignored.
  - Next start in IDLE with DIV 7/3 -> result=2, remainder=1, flags cleared on accept.
- SEQ_ALU_SIGNED_EN, WIDTH=4: DIV A=-7, B=2 -> quotient=-3, remainder=-1, negative=1; MUL -3*5 -> result=-15 (8'hF1), negative=1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle calculator ALU with a start/busy/done handshake.
// ADD/SUB take one compute cycle. MUL is a shift-add over WIDTH cycles.
// DIV is a restoring divider over WIDTH cycles. DIV by zero finishes in one cycle.
// Optional build macro SEQ_ALU_SIGNED_EN treats A and B as two's complement.
// In that build, MUL/DIV iterate on magnitudes and the sign is restored on
// the final iteration.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           op,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 negative,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int RW    = 2 * WIDTH;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a, r_b, r_bmag;
  logic [1:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [RW-1:0]      r_mcand, r_prod;
  logic [WIDTH-1:0]   r_mplier, r_rem, r_quot;
  logic               r_sa, r_sb;

  logic               w_inSa, w_inSb;
  logic [WIDTH-1:0]   w_inAmag, w_inBmag;
  logic [RW-1:0]      w_aExt, w_bExt, w_addRes, w_subRes;
  logic               w_addNeg, w_subNeg, w_mulNeg, w_divNeg, w_dbzNeg;
  logic [RW-1:0]      w_prodNext, w_mulRes, w_divQ;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH-1:0]   w_diff, w_remNext, w_quotNext, w_quotFix, w_remFix;
  logic               w_ge, w_lastIter;

`ifdef SEQ_ALU_SIGNED_EN
  assign w_inSa   = A[WIDTH-1];
  assign w_inSb   = B[WIDTH-1];
  assign w_aExt   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_bExt   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_addRes = w_aExt + w_bExt;
  assign w_subRes = w_aExt - w_bExt;
  assign w_addNeg = w_addRes[RW-1];
  assign w_subNeg = w_subRes[RW-1];
  assign w_divQ   = {{WIDTH{w_quotFix[WIDTH-1]}}, w_quotFix};
  assign w_mulNeg = w_mulRes[RW-1];
  assign w_divNeg = w_divQ[RW-1];
  assign w_dbzNeg = 1'b1;
`else
  assign w_inSa   = 1'b0;
  assign w_inSb   = 1'b0;
  assign w_aExt   = RW'(r_a);
  assign w_bExt   = RW'(r_b);
  assign w_addRes = w_aExt + w_bExt;
  assign w_subNeg = (r_a < r_b);
  assign w_subRes = w_subNeg ? (w_bExt - w_aExt) : (w_aExt - w_bExt);
  assign w_addNeg = 1'b0;
  assign w_divQ   = RW'(w_quotFix);
  assign w_mulNeg = 1'b0;
  assign w_divNeg = 1'b0;
  assign w_dbzNeg = 1'b0;
`endif

  // Operand magnitudes are captured at accept so the iterations are always unsigned.
  assign w_inAmag = w_inSa ? (WIDTH'(0) - A) : A;
  assign w_inBmag = w_inSb ? (WIDTH'(0) - B) : B;

  assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : RW'(0));
  assign w_mulRes   = (r_sa ^ r_sb) ? (RW'(0) - w_prodNext) : w_prodNext;

  // Restoring step: bring in the next dividend bit, subtract only if it fits.
  assign w_partial  = {r_rem, r_quot[WIDTH-1]};
  assign w_ge       = (w_partial >= {1'b0, r_bmag});
  assign w_diff     = w_partial[WIDTH-1:0] - r_bmag;
  assign w_remNext  = w_ge ? w_diff : w_partial[WIDTH-1:0];
  assign w_quotNext = {r_quot[WIDTH-2:0], w_ge};
  assign w_quotFix  = (r_sa ^ r_sb) ? (WIDTH'(0) - w_quotNext) : w_quotNext;
  assign w_remFix   = r_sa ? (WIDTH'(0) - w_remNext) : w_remNext;

  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  // Control FSM with registered outputs and the iterative datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bmag      <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      negative    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a         <= A;
            r_b         <= B;
            r_op        <= op;
            r_bmag      <= w_inBmag;
            r_sa        <= w_inSa;
            r_sb        <= w_inSb;
            r_mcand     <= RW'(w_inAmag);
            r_mplier    <= w_inBmag;
            r_prod      <= '0;
            r_rem       <= '0;
            r_quot      <= w_inAmag;
            r_cnt       <= '0;
            negative    <= 1'b0;
            div_by_zero <= 1'b0;
            remainder   <= '0;
            busy        <= 1'b1;
            r_state     <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_op == OP_ADD) begin
            result   <= w_addRes;
            negative <= w_addNeg;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_op == OP_SUB) begin
            result   <= w_subRes;
            negative <= w_subNeg;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_op == OP_MUL) begin
            r_prod   <= w_prodNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_lastIter) begin
              result   <= w_mulRes;
              negative <= w_mulNeg;
              busy     <= 1'b0;
              done     <= 1'b1;
              r_state  <= S_DONE;
            end
          end else if (r_b == '0) begin
            result      <= '1;
            remainder   <= r_a;
            div_by_zero <= 1'b1;
            negative    <= w_dbzNeg;
            busy        <= 1'b0;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_rem  <= w_remNext;
            r_quot <= w_quotNext;
            r_cnt  <= r_cnt + 1'b1;
            if (w_lastIter) begin
              result    <= w_divQ;
              remainder <= w_remFix;
              negative  <= w_divNeg;
              busy      <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed test of seq_alu at WIDTH=4 and WIDTH=8.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       start4, busy4, done4, neg4, dbz4;
  logic [3:0] a4, b4, rem4;
  logic [1:0] op4;
  logic [7:0] result4;

  logic        start8, busy8, done8, neg8, dbz8;
  logic [7:0]  a8, b8, rem8;
  logic [1:0]  op8;
  logic [15:0] result8;

  int assertCount = 0;
  int failCount   = 0;

  // 10-unit clock period shared by both instances.
  always #5 clk = ~clk;

  seq_alu #(.WIDTH(4)) u_alu4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .A(a4), .B(b4), .op(op4),
    .busy(busy4), .done(done4), .result(result4), .remainder(rem4),
    .negative(neg4), .div_by_zero(dbz4)
  );

  seq_alu #(.WIDTH(8)) u_alu8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .A(a8), .B(b8), .op(op8),
    .busy(busy8), .done(done8), .result(result8), .remainder(rem8),
    .negative(neg8), .div_by_zero(dbz8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic runOp4(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                        output int lat);
    @(negedge clk);
    a4 = a; b4 = b; op4 = o; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checkOutput("busy4AfterAccept", busy4, 1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done4) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runOp8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    @(negedge clk);
    a8 = a; b8 = b; op8 = o; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("busy8AfterAccept", busy8, 1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus;
    int lat;
    int doneSeen;

    reset_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; op4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy8", busy8, 0);
    checkOutput("rstDone8", done8, 0);
    checkOutput("rstResult8", result8, 0);
    checkOutput("rstRem8", rem8, 0);
    checkOutput("rstFlags8", {neg8, dbz8}, 0);
    checkOutput("rstBusy4", busy4, 0);
    reset_n = 1'b1;

    // WIDTH=4 SUB with A<B gives the magnitude and a negative flag.
    runOp4(2'b01, 4'd3, 4'd5, lat);
    checkOutput("sub4Lat", lat, 1);
    checkOutput("sub4Result", result4, 2);
    checkOutput("sub4Neg", neg4, 1);
    @(negedge clk);
    checkOutput("sub4DonePulse", done4, 0);

    // WIDTH=4 MUL aborted by reset two cycles after accept.
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd5; op4 = 2'b10; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mul4BusyPreRst", busy4, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abortBusy", busy4, 0);
    checkOutput("abortDone", done4, 0);
    checkOutput("abortResult", result4, 0);
    checkOutput("abortFlags", {neg4, dbz4, rem4}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    doneSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) doneSeen++;
    end
    checkOutput("abortNoDone", doneSeen, 0);
    checkOutput("abortIdle", busy4, 0);

    runOp4(2'b00, 4'd5, 4'd3, lat);
    checkOutput("add4Lat", lat, 1);
    checkOutput("add4Result", result4, 8);
    checkOutput("add4Neg", neg4, 0);

    // WIDTH=8 arithmetic.
    runOp8(2'b00, 8'd200, 8'd100, lat);
    checkOutput("add8Lat", lat, 1);
    checkOutput("add8Result", result8, 300);

    runOp8(2'b10, 8'd255, 8'd255, lat);
    checkOutput("mul8Lat", lat, 8);
    checkOutput("mul8Result", result8, 65025);
    checkOutput("mul8Rem", rem8, 0);

    runOp8(2'b11, 8'd200, 8'd7, lat);
    checkOutput("div8Lat", lat, 8);
    checkOutput("div8Quot", result8, 28);
    checkOutput("div8Rem", rem8, 4);
    checkOutput("div8Flags", {neg8, dbz8}, 0);

    runOp8(2'b11, 8'd9, 8'd0, lat);
    checkOutput("dbzLat", lat, 1);
    checkOutput("dbzFlag", dbz8, 1);
    checkOutput("dbzResult", result8, 16'hFFFF);
    checkOutput("dbzRem", rem8, 9);

    // MUL with start held high and operands toggled during CALC.
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd10; op8 = 2'b10; start8 = 1'b1;
    @(negedge clk);
    checkOutput("hsBusy", busy8, 1);
    checkOutput("hsFlagsCleared", {dbz8, rem8}, 0);
    doneSeen = 0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      a8 = a8 ^ 8'hFF;
      b8 = 8'(i * 3);
      op8 = 2'b11;
      if (done8) begin
        lat = i;
        doneSeen++;
        break;
      end
    end
    checkOutput("hsLat", lat, 8);
    checkOutput("hsResult", result8, 120);
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("hsStartInDoneIgnored", busy8, 0);
    checkOutput("hsDoneOnePulse", done8, 0);
    repeat (4) begin
      @(negedge clk);
      if (done8) doneSeen++;
    end
    checkOutput("hsDoneCount", doneSeen, 1);
    checkOutput("hsResultHeld", result8, 120);

    runOp8(2'b11, 8'd7, 8'd3, lat);
    checkOutput("div73Lat", lat, 8);
    checkOutput("div73Quot", result8, 2);
    checkOutput("div73Rem", rem8, 1);
    checkOutput("div73Flags", {neg8, dbz8}, 0);

`ifdef SEQ_ALU_SIGNED_EN
    // Signed build: truncating division and sign-restored product.
    runOp4(2'b11, 4'b1001, 4'd2, lat);
    checkOutput("sDivLat", lat, 4);
    checkOutput("sDivQuot", result4, 8'hFD);
    checkOutput("sDivRem", rem4, 4'hF);
    checkOutput("sDivNeg", neg4, 1);

    runOp4(2'b10, 4'b1101, 4'd5, lat);
    checkOutput("sMulLat", lat, 4);
    checkOutput("sMulResult", result4, 8'hF1);
    checkOutput("sMulNeg", neg4, 1);
`endif
  endtask

  // Main sequence followed by the single summary line.
  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
